// File: rtl/multi_edge_detector_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode
// encodings, control FSM states and the direction qualification helper.
`timescale 1ns/1ps
package multi_edge_detector_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

    function automatic logic edge_enabled(input edge_mode_e m, input logic rising);
        case (m)
            MODE_RISE: return rising;
            MODE_FALL: return !rising;
            MODE_BOTH: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Bundle of the per-channel input lines, controls and detector outputs.
`timescale 1ns/1ps
interface multi_edge_detector_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8
);
    logic [NUM_CH-1:0]           sig;
    logic [2*NUM_CH-1:0]         mode;
    logic [NUM_CH-1:0]           clr;
    logic [NUM_CH-1:0]           level;
    logic [NUM_CH-1:0]           edge_pulse;
    logic [NUM_CH-1:0]           edge_flag;
    logic [NUM_CH*CNT_WIDTH-1:0] edge_cnt;
    logic                        ready;

    modport master (
        output sig, mode, clr,
        input  level, edge_pulse, edge_flag, edge_cnt, ready
    );

    modport slave (
        input  sig, mode, clr,
        output level, edge_pulse, edge_flag, edge_cnt, ready
    );
endinterface

// File: rtl/multi_edge_detector_edge_channel.sv
// One detector channel: synchroniser, glitch filter, edge qualification,
// sticky flag and saturating edge counter.
`timescale 1ns/1ps
module edge_channel
    import multi_edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig,
    input  logic [1:0]           mode,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 run,
    output logic                 level,
    output logic                 edge_pulse,
    output logic                 edge_flag,
    output logic [CNT_WIDTH-1:0] edge_cnt
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          filt_cnt;
    logic                   s;
    logic                   toggle;
    logic                   fire;

    assign s = sync_q[SYNC_STAGES-1];

    // Level flips on the edge where the mismatch run would reach FILTER_LEN.
    always_comb begin
        toggle = run && (s != level) && (filt_cnt == FILT_LAST);
        fire   = toggle && edge_enabled(edge_mode_e'(mode), !level);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            filt_cnt   <= '0;
            level      <= 1'b0;
            edge_pulse <= 1'b0;
            edge_flag  <= 1'b0;
            edge_cnt   <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig};
            edge_pulse <= fire;
            if (load) begin
                level    <= s;
                filt_cnt <= '0;
            end else if (run) begin
                if (s == level || toggle)
                    filt_cnt <= '0;
                else
                    filt_cnt <= filt_cnt + 1'b1;
                if (toggle)
                    level <= ~level;
                // Flag and count move together with the pulse; an edge wins over clr.
                if (clr) begin
                    edge_flag <= fire;
                    edge_cnt  <= CNT_WIDTH'(fire);
                end else if (fire) begin
                    edge_flag <= 1'b1;
                    if (edge_cnt != '1)
                        edge_cnt <= edge_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: shared PRIME/RUN control plus NUM_CH
// independent edge_channel instances.
`timescale 1ns/1ps
module multi_edge_detector
    import multi_edge_detector_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_WIDTH   = 8
) (
    input logic             sys_clk,
    input logic             rst,
    multi_edge_detector_if.slave bus
);
    localparam int PW = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);

    ctrl_state_e   state;
    logic [PW-1:0] prime_cnt;
    logic          ready_q;
    logic          load;
    logic          run;

    // Last PRIME cycle: synchroniser is full, so level can be loaded silently.
    assign load      = (state == ST_PRIME) && (prime_cnt == PRIME_LAST);
    assign run       = (state == ST_RUN);
    assign bus.ready = ready_q;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                ST_PRIME: begin
                    if (load) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        prime_cnt <= prime_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_PRIME;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_ch (
            .clk       (sys_clk),
            .rst_n     (rst),
            .sig       (bus.sig[i]),
            .mode      (bus.mode[2*i +: 2]),
            .clr       (bus.clr[i]),
            .load      (load),
            .run       (run),
            .level     (bus.level[i]),
            .edge_pulse(bus.edge_pulse[i]),
            .edge_flag (bus.edge_flag[i]),
            .edge_cnt  (bus.edge_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed and scoreboarded checks of multi_edge_detector with default parameters.
`timescale 1ns/1ps
module tb_multi_edge_detector;
    localparam int NCH  = 4;
    localparam int SYNC = 2;
    localparam int FLEN = 3;
    localparam int CW   = 8;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   n_vec   = 0;
    int   n_bad   = 0;

    multi_edge_detector_if #(.NUM_CH(NCH), .CNT_WIDTH(CW)) bus ();

    multi_edge_detector #(
        .NUM_CH(NCH), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .CNT_WIDTH(CW)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] sig;
        logic [7:0] mode;
        logic [3:0] exp_level;
        logic [3:0] exp_pulse;
        logic [3:0] exp_flag;
    } vec_t;

    vec_t tbl [11];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int c);
        return 32'(bus.edge_cnt[c*CW +: CW]);
    endfunction

    task automatic reset_prime(input logic [3:0] s, input logic [7:0] m);
        rst      = 1'b0;
        bus.sig  = s;
        bus.mode = m;
        bus.clr  = '0;
        step();
        step();
        rst = 1'b1;
        step();
        step();
        step();
    endtask

    // Scoreboard state for the randomised phase.
    logic       m_s0 [NCH];
    logic       m_s1 [NCH];
    logic       m_lvl[NCH];
    int         m_d  [NCH];
    int         m_cnt[NCH];
    logic [3:0] m_pulse, m_flag;
    logic [31:0] m_cnt_v;
    int         cd   [NCH];
    logic [3:0] rsig, rclr;
    logic [7:0] rmode;
    logic [1:0] md;
    logic       fire;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'hF, 8'b11_10_01_00, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'hF, 8'b11_10_01_00, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{4'hF, 8'b11_10_01_00, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{4'hF, 8'b11_10_01_00, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{4'hF, 8'b11_10_01_00, 4'hF, 4'hA, 4'hA};
        tbl[5]  = '{4'h0, 8'b11_10_01_00, 4'hF, 4'h0, 4'hA};
        tbl[6]  = '{4'h0, 8'b11_10_01_00, 4'hF, 4'h0, 4'hA};
        tbl[7]  = '{4'h0, 8'b11_10_01_00, 4'hF, 4'h0, 4'hA};
        tbl[8]  = '{4'h0, 8'b11_10_01_00, 4'hF, 4'h0, 4'hA};
        tbl[9]  = '{4'h0, 8'b11_10_01_00, 4'h0, 4'hC, 4'hE};
        tbl[10] = '{4'h0, 8'b11_10_01_00, 4'h0, 4'h0, 4'hE};

        // Prime with high inputs held through reset
        bus.sig  = 4'b1010;
        bus.mode = 8'hFF;
        bus.clr  = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_pulse", 32'(bus.edge_pulse), 0);
        chk("rst_flag",  32'(bus.edge_flag), 0);
        chk("rst_cnt",   bus.edge_cnt, 0);
        chk("rst_ready", 32'(bus.ready), 0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("prime1_ready", 32'(bus.ready), 0);
        chk("prime1_level", 32'(bus.level), 0);
        step();
        chk("prime2_ready", 32'(bus.ready), 0);
        chk("prime2_level", 32'(bus.level), 0);
        step();
        chk("prime3_ready", 32'(bus.ready), 1);
        chk("prime3_level", 32'(bus.level), 32'hA);
        chk("prime3_pulse", 32'(bus.edge_pulse), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("prime_post_pulse", 32'(bus.edge_pulse), 0);
        end
        chk("prime_cnt", bus.edge_cnt, 0);
        chk("prime_flag", 32'(bus.edge_flag), 0);

        // Rise/fall qualification per mode
        reset_prime(4'b0000, 8'b11_10_01_00);
        for (int j = 0; j < 11; j++) begin
            bus.sig  = tbl[j].sig;
            bus.mode = tbl[j].mode;
            step();
            chk("tbl_level", 32'(bus.level), 32'(tbl[j].exp_level));
            chk("tbl_pulse", 32'(bus.edge_pulse), 32'(tbl[j].exp_pulse));
            chk("tbl_flag",  32'(bus.edge_flag), 32'(tbl[j].exp_flag));
        end
        chk("tbl_cnt", bus.edge_cnt, 32'h02_01_01_00);

        // Glitch rejection on ch0, then a qualifying 3-cycle pulse
        reset_prime(4'b0000, 8'b00_00_00_01);
        for (int i = 1; i <= 8; i++) begin
            bus.sig[0] = (i <= 2);
            step();
            chk("glitch_level", 32'(bus.level[0]), 0);
            chk("glitch_pulse", 32'(bus.edge_pulse[0]), 0);
        end
        for (int i = 1; i <= 10; i++) begin
            bus.sig[0] = (i <= 3);
            step();
            chk("pass_pulse", 32'(bus.edge_pulse[0]), 32'(i == 5));
            chk("pass_level", 32'(bus.level[0]), 32'(i >= 5 && i <= 7));
        end
        chk("pass_cnt", cnt_of(0), 1);
        chk("pass_flag", 32'(bus.edge_flag), 32'h1);

        // Counter saturation and clear on ch1
        reset_prime(4'b0000, 8'b00_00_01_00);
        for (int n = 0; n < 300; n++) begin
            bus.sig[1] = 1'b1;
            repeat (4) step();
            bus.sig[1] = 1'b0;
            repeat (4) step();
        end
        repeat (2) step();
        chk("sat_cnt", cnt_of(1), 255);
        chk("sat_flag", 32'(bus.edge_flag), 32'h2);
        chk("sat_other_cnt", bus.edge_cnt & 32'hFFFF_00FF, 0);
        bus.sig[1] = 1'b1;
        repeat (4) step();
        bus.clr = 4'b0010;
        step();
        chk("clr_edge_pulse", 32'(bus.edge_pulse[1]), 1);
        chk("clr_edge_cnt", cnt_of(1), 1);
        chk("clr_edge_flag", 32'(bus.edge_flag[1]), 1);
        bus.clr    = '0;
        bus.sig[1] = 1'b0;
        repeat (5) step();
        chk("clr_hold_cnt", cnt_of(1), 1);
        bus.clr = 4'b0010;
        step();
        bus.clr = '0;
        chk("clr_only_cnt", cnt_of(1), 0);
        chk("clr_only_flag", 32'(bus.edge_flag[1]), 0);

        // Asynchronous reset mid-operation
        reset_prime(4'b0000, 8'b00_00_01_00);
        for (int n = 0; n < 6; n++) begin
            bus.sig[1] = 1'b1;
            repeat (4) step();
            bus.sig[1] = 1'b0;
            repeat (4) step();
        end
        bus.sig[1] = 1'b1;
        repeat (6) step();
        chk("pre_rst_level", 32'(bus.level), 32'h2);
        chk("pre_rst_cnt", cnt_of(1), 7);
        bus.mode = 8'hFF;
        rst = 1'b0;
        #0.5;
        chk("mid_rst_level", 32'(bus.level), 0);
        chk("mid_rst_flag",  32'(bus.edge_flag), 0);
        chk("mid_rst_cnt",   bus.edge_cnt, 0);
        chk("mid_rst_ready", 32'(bus.ready), 0);
        #0.5 rst = 1'b1;
        step();
        chk("rep1_ready", 32'(bus.ready), 0);
        step();
        chk("rep2_ready", 32'(bus.ready), 0);
        chk("rep2_level", 32'(bus.level), 0);
        step();
        chk("rep3_ready", 32'(bus.ready), 1);
        chk("rep3_level", 32'(bus.level), 32'h2);
        chk("rep3_pulse", 32'(bus.edge_pulse), 0);
        step();
        chk("rep4_pulse", 32'(bus.edge_pulse), 0);
        chk("rep4_cnt", bus.edge_cnt, 0);

        // Randomised toggling against the scoreboard
        reset_prime(4'b0000, 8'h00);
        rsig  = '0;
        rmode = '0;
        m_pulse = '0;
        m_flag  = '0;
        for (int c = 0; c < NCH; c++) begin
            m_s0[c] = 1'b0; m_s1[c] = 1'b0; m_lvl[c] = 1'b0;
            m_d[c] = 0; m_cnt[c] = 0;
            cd[c] = int'($urandom_range(3, 1));
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (cd[c] == 0) begin
                    rsig[c] = ~rsig[c];
                    cd[c]   = int'($urandom_range(3, 1));
                end else begin
                    cd[c]--;
                end
            end
            if ($urandom_range(7, 0) == 0)
                rmode = 8'($urandom);
            for (int c = 0; c < NCH; c++)
                rclr[c] = ($urandom_range(9, 0) == 0);
            bus.sig  = rsig;
            bus.mode = rmode;
            bus.clr  = rclr;

            for (int c = 0; c < NCH; c++) begin
                md   = rmode[2*c +: 2];
                fire = 1'b0;
                if (m_s1[c] != m_lvl[c]) m_d[c]++;
                else                     m_d[c] = 0;
                if (m_d[c] == FLEN) begin
                    fire     = m_lvl[c] ? (md == 2'b10 || md == 2'b11)
                                        : (md == 2'b01 || md == 2'b11);
                    m_lvl[c] = ~m_lvl[c];
                    m_d[c]   = 0;
                end
                m_pulse[c] = fire;
                if (rclr[c]) begin
                    m_flag[c] = fire;
                    m_cnt[c]  = fire ? 1 : 0;
                end else if (fire) begin
                    m_flag[c] = 1'b1;
                    if (m_cnt[c] < 255) m_cnt[c]++;
                end
                m_s1[c] = m_s0[c];
                m_s0[c] = rsig[c];
            end
            for (int c = 0; c < NCH; c++)
                m_cnt_v[c*CW +: CW] = 8'(m_cnt[c]);

            step();
            chk("rnd_level", 32'(bus.level),
                32'({m_lvl[3], m_lvl[2], m_lvl[1], m_lvl[0]}));
            chk("rnd_pulse", 32'(bus.edge_pulse), 32'(m_pulse));
            chk("rnd_flag",  32'(bus.edge_flag), 32'(m_flag));
            chk("rnd_cnt",   bus.edge_cnt, m_cnt_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
